// File: rtl/project_shadow_register_file_pkg.sv
// project_regfile_pkg: shared constants and address helpers for the shadow
// register file. Optional feature macro: PROJECT_SHADOW_READBACK_EN.
package project_regfile_pkg;

  // GCR bit positions
  localparam int GCR_LOCK  = 0;
  localparam int GCR_ERR   = 1;
  localparam int GCR_RDSEL = 2;

  // Per-channel control register index (holds the IMM bit in its MSB)
  localparam int CTRL_REG = 0;

  // IMM lives in the top bit of the control register
  function automatic int imm_bit(input int data_width);
    return data_width - 1;
  endfunction

  // Global control register sits right after the last channel register
  function automatic int gcr_offset(input int num_channels, input int regs_per_channel);
    return num_channels * regs_per_channel;
  endfunction

  // FORCE register follows GCR
  function automatic int force_offset(input int num_channels, input int regs_per_channel);
    return num_channels * regs_per_channel + 1;
  endfunction

  // Width of a register index inside one channel (at least one bit)
  function automatic int reg_idx_width(input int regs_per_channel);
    return (regs_per_channel > 1) ? $clog2(regs_per_channel) : 1;
  endfunction

endpackage

// File: rtl/project_shadow_register_file_if.sv
// Host bus between the address decoder and the shadow register file.
interface project_shadow_register_file_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  i_write_en;
  logic                  i_read_en;
  logic [ADDR_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_rd_valid;

  modport master (output i_write_en, i_read_en, i_address, i_data,
                  input  o_data, o_rd_valid);
  modport slave  (input  i_write_en, i_read_en, i_address, i_data,
                  output o_data, o_rd_valid);
endinterface

// File: rtl/project_shadow_register_file_channel.sv
// One PWM channel: pending bank, active bank, dirty flag and commit logic.
module project_shadow_channel
  import project_regfile_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int REGS_PER_CHANNEL = 16,
  parameter int RW               = 4
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_wr_en,
  input  logic [RW-1:0]                        i_wr_reg,
  input  logic [DATA_WIDTH-1:0]                i_wr_data,
  input  logic                                 i_sync,
  input  logic                                 i_force,
  output logic [REGS_PER_CHANNEL*DATA_WIDTH-1:0] o_pending,
  output logic [REGS_PER_CHANNEL*DATA_WIDTH-1:0] o_active,
  output logic                                 o_dirty
);
  logic [DATA_WIDTH-1:0] r_pending [REGS_PER_CHANNEL];
  logic [DATA_WIDTH-1:0] r_active  [REGS_PER_CHANNEL];
  logic                  r_dirty;
  logic                  w_imm;
  logic                  w_commit;

  assign w_imm    = r_active[CTRL_REG][imm_bit(DATA_WIDTH)];
  assign w_commit = (i_sync & r_dirty) | i_force;

  genvar gi;
  generate
    for (gi = 0; gi < REGS_PER_CHANNEL; gi++) begin : g_reg
      logic w_hit;
      assign w_hit = i_wr_en && (i_wr_reg == RW'(gi));

      // Pending takes CPU data; active takes the whole pre-write pending bank on
      // commit, except that an immediate-mode write lands straight in active.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_pending[gi] <= '0;
          r_active[gi]  <= '0;
        end else begin
          if (w_hit) r_pending[gi] <= i_wr_data;
          if (w_hit && w_imm) r_active[gi] <= i_wr_data;
          else if (w_commit)  r_active[gi] <= r_pending[gi];
        end
      end

      assign o_pending[gi*DATA_WIDTH +: DATA_WIDTH] = r_pending[gi];
      assign o_active[gi*DATA_WIDTH +: DATA_WIDTH]  = r_active[gi];
    end
  endgenerate

  // A buffered write marks the bank dirty and wins over a same-cycle commit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)            r_dirty <= 1'b0;
    else if (i_wr_en && !w_imm) r_dirty <= 1'b1;
    else if (w_commit)         r_dirty <= 1'b0;
  end

  assign o_dirty = r_dirty;
endmodule

// File: rtl/project_shadow_register_file.sv
// Double-buffered PWM register file: address decode, GCR, error flag and
// registered readback. Optional macro PROJECT_SHADOW_READBACK_EN enables
// GCR.RDSEL (channel reads return the active bank).
module project_shadow_register_file
  import project_regfile_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 6,
  parameter int NUM_CHANNELS     = 3,
  parameter int REGS_PER_CHANNEL = 16
) (
  input  logic                                              i_clk,
  input  logic                                              i_reset_n,
  project_shadow_register_file_if.slave                     bus,
  input  logic [NUM_CHANNELS-1:0]                           i_sync,
  output logic [NUM_CHANNELS*REGS_PER_CHANNEL*DATA_WIDTH-1:0] o_active_regs,
  output logic [NUM_CHANNELS-1:0]                           o_dirty,
  output logic                                              o_wr_error
);
  localparam int TOTAL  = NUM_CHANNELS * REGS_PER_CHANNEL;
  localparam int G_ADDR = gcr_offset(NUM_CHANNELS, REGS_PER_CHANNEL);
  localparam int F_ADDR = force_offset(NUM_CHANNELS, REGS_PER_CHANNEL);
  localparam int RW     = reg_idx_width(REGS_PER_CHANNEL);
  localparam int IW     = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int BANK_W = REGS_PER_CHANNEL * DATA_WIDTH;

  generate
    if (TOTAL + 2 > 2**ADDR_WIDTH) begin : g_bad_addr_width
      $error("address space too small for channels plus GCR/FORCE");
    end
    if (DATA_WIDTH < NUM_CHANNELS || DATA_WIDTH < 3) begin : g_bad_data_width
      $error("DATA_WIDTH must cover NUM_CHANNELS and the GCR bits");
    end
  endgenerate

  logic [31:0]             w_addr;
  logic [31:0]             w_ch_sel;
  logic [RW-1:0]           w_reg_sel;
  logic [IW-1:0]           w_flat_idx;
  logic                    w_is_chan, w_is_gcr, w_is_force, w_is_unmapped;
  logic                    w_wr_chan_ok, w_wr_reject, w_wr_gcr;
  logic [NUM_CHANNELS-1:0] w_force;
  logic                    w_rdsel;
  logic [DATA_WIDTH-1:0]   w_rd_value;
  logic [DATA_WIDTH-1:0]   w_pend_flat [TOTAL];
  logic [DATA_WIDTH-1:0]   w_act_flat  [TOTAL];
  logic                    r_lock, r_err, r_rd_valid;
  logic [DATA_WIDTH-1:0]   r_data;

  assign w_addr        = 32'(bus.i_address);
  assign w_ch_sel      = w_addr / 32'(REGS_PER_CHANNEL);
  assign w_reg_sel     = RW'(w_addr % 32'(REGS_PER_CHANNEL));
  assign w_flat_idx    = IW'(w_addr);
  assign w_is_chan     = w_addr < 32'(TOTAL);
  assign w_is_gcr      = w_addr == 32'(G_ADDR);
  assign w_is_force    = w_addr == 32'(F_ADDR);
  assign w_is_unmapped = w_addr > 32'(F_ADDR);

  // Lock only blocks channel writes; GCR and FORCE stay reachable
  assign w_wr_chan_ok = bus.i_write_en & w_is_chan & ~r_lock;
  assign w_wr_reject  = bus.i_write_en & ((w_is_chan & r_lock) | w_is_unmapped);
  assign w_wr_gcr     = bus.i_write_en & w_is_gcr;
  assign w_force      = (bus.i_write_en & w_is_force) ? bus.i_data[NUM_CHANNELS-1:0] : '0;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      logic              w_sel_wr;
      logic [BANK_W-1:0] w_pending_bank;
      logic [BANK_W-1:0] w_active_bank;

      assign w_sel_wr = w_wr_chan_ok && (w_ch_sel == 32'(gi));

      project_shadow_channel #(
        .DATA_WIDTH(DATA_WIDTH), .REGS_PER_CHANNEL(REGS_PER_CHANNEL), .RW(RW)
      ) u_chan (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_wr_en(w_sel_wr), .i_wr_reg(w_reg_sel), .i_wr_data(bus.i_data),
        .i_sync(i_sync[gi]), .i_force(w_force[gi]),
        .o_pending(w_pending_bank), .o_active(w_active_bank), .o_dirty(o_dirty[gi])
      );

      assign o_active_regs[gi*BANK_W +: BANK_W] = w_active_bank;
      for (gj = 0; gj < REGS_PER_CHANNEL; gj++) begin : g_flat
        assign w_pend_flat[gi*REGS_PER_CHANNEL+gj] = w_pending_bank[gj*DATA_WIDTH +: DATA_WIDTH];
        assign w_act_flat[gi*REGS_PER_CHANNEL+gj]  = w_active_bank[gj*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  endgenerate

  // LOCK follows GCR writes; ERR is sticky and a same-cycle rejection beats W1C
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lock <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      if (w_wr_gcr) r_lock <= bus.i_data[GCR_LOCK];
      if (w_wr_reject)                             r_err <= 1'b1;
      else if (w_wr_gcr && bus.i_data[GCR_ERR])    r_err <= 1'b0;
    end
  end

`ifdef PROJECT_SHADOW_READBACK_EN
  logic r_rdsel;
  // RDSEL selects which bank channel reads return
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)    r_rdsel <= 1'b0;
    else if (w_wr_gcr) r_rdsel <= bus.i_data[GCR_RDSEL];
  end
  assign w_rdsel = r_rdsel;
`else
  assign w_rdsel = 1'b0;
`endif

  // Readback mux over the pre-edge state, so a same-cycle write reads old data
  always_comb begin
    w_rd_value = '0;
    if (w_is_chan) begin
      w_rd_value = w_rdsel ? w_act_flat[w_flat_idx] : w_pend_flat[w_flat_idx];
    end else if (w_is_gcr) begin
      w_rd_value[GCR_LOCK]  = r_lock;
      w_rd_value[GCR_ERR]   = r_err;
      w_rd_value[GCR_RDSEL] = w_rdsel;
    end
  end

  // One-cycle read pipeline; data holds between reads
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_data     <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.i_read_en;
      if (bus.i_read_en) r_data <= w_rd_value;
    end
  end

  assign bus.o_data     = r_data;
  assign bus.o_rd_valid = r_rd_valid;
  assign o_wr_error     = r_err;
endmodule

// File: tb/tb_project_shadow_register_file.sv
// Self-checking bench for project_shadow_register_file (optionally built with
// PROJECT_SHADOW_READBACK_EN).
module tb_project_shadow_register_file;
  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NC = 3;
  localparam int R  = 16;
  localparam int G  = NC * R;
  localparam int BW = NC * R * DW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] sync;
  logic [BW-1:0] active_regs;
  logic [NC-1:0] dirty;
  logic          wr_error;

  project_shadow_register_file_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  project_shadow_register_file #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CHANNELS(NC), .REGS_PER_CHANNEL(R)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .bus(bus), .i_sync(sync),
    .o_active_regs(active_regs), .o_dirty(dirty), .o_wr_error(wr_error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: the register file as the programmer sees it
  logic [DW-1:0] m_pend [NC][R];
  logic [DW-1:0] m_act  [NC][R];
  logic [NC-1:0] m_dirty;
  logic          m_lock, m_err, m_rdsel, m_rvalid;
  logic [DW-1:0] m_rdata;

  task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] act_of(input int c, input int r);
    return active_regs[(c*R+r)*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < R; r++) begin
        m_pend[c][r] = '0;
        m_act[c][r]  = '0;
      end
    m_dirty = '0; m_lock = 0; m_err = 0; m_rdsel = 0; m_rvalid = 0; m_rdata = '0;
  endtask

  function automatic logic [DW-1:0] model_read(input int a);
    if (a < G) return m_rdsel ? m_act[a/R][a%R] : m_pend[a/R][a%R];
    if (a == G) return DW'({m_rdsel, m_err, m_lock});
    return '0;
  endfunction

  function automatic logic [BW-1:0] model_flat();
    logic [BW-1:0] v = '0;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < R; r++) v[(c*R+r)*DW +: DW] = m_act[c][r];
    return v;
  endfunction

  // Apply one bus/sync cycle to the reference state
  task automatic model_step();
    int            a = int'(bus.i_address);
    logic [DW-1:0] d = bus.i_data;
    logic [DW-1:0] snap [NC][R];
    logic [NC-1:0] frc = '0;
    logic [NC-1:0] mark = '0;
    bit            reject = 0, clr = 0, imm_hit = 0, commit;
    int            wc = 0, wreg = 0;
    m_rvalid = bus.i_read_en;
    if (bus.i_read_en) m_rdata = model_read(a);
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < R; r++) snap[c][r] = m_pend[c][r];
    if (bus.i_write_en) begin
      if (a < G) begin
        if (m_lock) reject = 1;
        else begin
          wc = a / R; wreg = a % R;
          m_pend[wc][wreg] = d;
          if (m_act[wc][0][DW-1]) imm_hit = 1;
          else mark[wc] = 1;
        end
      end else if (a == G) begin
        m_lock = d[0];
        clr    = d[1];
`ifdef PROJECT_SHADOW_READBACK_EN
        m_rdsel = d[2];
`endif
      end else if (a == G + 1) begin
        frc = d[NC-1:0];
      end else begin
        reject = 1;
      end
    end
    for (int c = 0; c < NC; c++) begin
      commit = (sync[c] && m_dirty[c]) || frc[c];
      if (commit)
        for (int r = 0; r < R; r++) m_act[c][r] = snap[c][r];
      if (mark[c])     m_dirty[c] = 1'b1;
      else if (commit) m_dirty[c] = 1'b0;
    end
    if (imm_hit) m_act[wc][wreg] = d;
    if (reject) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  always @(posedge clk) if (rst_n) model_step();

  // Compare every output against the reference on every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      check("active_regs", active_regs, model_flat());
      check("dirty", BW'(dirty), BW'(m_dirty));
      check("wr_error", BW'(wr_error), BW'(m_err));
      check("rd_valid", BW'(bus.o_rd_valid), BW'(m_rvalid));
      check("o_data", BW'(bus.o_data), BW'(m_rdata));
    end
  end

  task automatic cyc(input bit we, input bit re, input int a, input logic [DW-1:0] d,
                     input logic [NC-1:0] s);
    bus.i_write_en = we; bus.i_read_en = re; bus.i_address = AW'(a);
    bus.i_data = d; sync = s;
    @(negedge clk);
    bus.i_write_en = 0; bus.i_read_en = 0; sync = '0;
  endtask

  initial begin
    bus.i_write_en = 0; bus.i_read_en = 0; bus.i_address = '0; bus.i_data = '0; sync = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_active", active_regs, '0);
    check("reset_dirty", BW'(dirty), '0);
    check("reset_err", BW'(wr_error), '0);
    check("reset_rd_valid", BW'(bus.o_rd_valid), '0);
    check("reset_o_data", BW'(bus.o_data), '0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Read the whole map after reset
    for (int a = 0; a < 2**AW; a++) begin
      cyc(0, 1, a, '0, '0);
      check("reset_read_valid", BW'(bus.o_rd_valid), BW'(1));
      check("reset_read_data", BW'(bus.o_data), '0);
      cyc(0, 0, 0, '0, '0);
    end

    // Buffered write, then commit on sync, then idle sync
    cyc(1, 0, R + 4, 8'hA5, '0);
    check("ch1r4_pre_sync", BW'(act_of(1, 4)), BW'(8'h00));
    check("dirty_ch1", BW'(dirty), BW'(3'b010));
    cyc(0, 0, 0, '0, 3'b010);
    check("ch1r4_synced", BW'(act_of(1, 4)), BW'(8'hA5));
    check("dirty_clear", BW'(dirty), BW'(3'b000));
    cyc(0, 0, 0, '0, 3'b010);
    check("ch1r4_idle_sync", BW'(act_of(1, 4)), BW'(8'hA5));

    // Write colliding with commit
    cyc(1, 0, 2, 8'h22, '0);
    cyc(1, 0, 2, 8'h11, 3'b001);
    check("collide_active", BW'(act_of(0, 2)), BW'(8'h22));
    check("collide_dirty", BW'(dirty[0]), BW'(1));
    cyc(0, 1, 2, '0, '0);
    check("collide_pending", BW'(bus.o_data), BW'(8'h11));
    cyc(0, 0, 0, '0, 3'b001);
    check("collide_second_sync", BW'(act_of(0, 2)), BW'(8'h11));

    // Lock rejects channel writes
    cyc(1, 0, G, 8'h01, '0);
    cyc(1, 0, 2*R + 1, 8'hFF, '0);
    check("locked_err", BW'(wr_error), BW'(1));
    cyc(0, 1, 2*R + 1, '0, '0);
    check("locked_pending", BW'(bus.o_data), BW'(8'h00));
    cyc(1, 0, G, 8'h02, '0);
    check("err_w1c", BW'(wr_error), BW'(0));
    cyc(0, 1, G, '0, '0);
    check("gcr_cleared", BW'(bus.o_data), BW'(8'h00));

    // Immediate mode and forced commit
    cyc(1, 0, 2*R, 8'h80, '0);
    check("ctrl_dirty", BW'(dirty), BW'(3'b100));
    cyc(0, 0, 0, '0, 3'b100);
    check("ctrl_active", BW'(act_of(2, 0)), BW'(8'h80));
    cyc(1, 0, 2*R + 3, 8'h5A, '0);
    check("imm_active", BW'(act_of(2, 3)), BW'(8'h5A));
    check("imm_no_dirty", BW'(dirty), BW'(3'b000));
    cyc(1, 0, 5, 8'h33, '0);
    check("pre_force_dirty", BW'(dirty), BW'(3'b001));
    cyc(1, 0, G + 1, 8'h01, '0);
    check("force_active", BW'(act_of(0, 5)), BW'(8'h33));
    check("force_dirty", BW'(dirty), BW'(3'b000));

    // Unmapped access and RDSEL
    cyc(1, 0, G + 2, 8'h77, '0);
    check("unmapped_err", BW'(wr_error), BW'(1));
    cyc(0, 1, G + 2, '0, '0);
    check("unmapped_read", BW'(bus.o_data), BW'(8'h00));
    cyc(1, 0, G, 8'h06, '0);
    cyc(0, 1, G, '0, '0);
`ifdef PROJECT_SHADOW_READBACK_EN
    check("gcr_rdsel", BW'(bus.o_data), BW'(8'h04));
    cyc(1, 0, R + 4, 8'h3C, '0);
    cyc(0, 1, R + 4, '0, '0);
    check("rdsel_active", BW'(bus.o_data), BW'(8'hA5));
    cyc(1, 0, G, 8'h00, '0);
`else
    check("gcr_no_rdsel", BW'(bus.o_data), BW'(8'h00));
`endif

    // Random traffic against the reference
    for (int i = 0; i < 2000; i++) begin
      int            a  = int'($urandom_range(0, 2**AW - 1));
      logic [DW-1:0] d  = DW'($urandom);
      bit            we = ($urandom_range(0, 2) == 0);
      bit            re = $urandom_range(0, 1) == 1;
      logic [NC-1:0] s  = NC'($urandom);
      if (a == G) d[0] = ($urandom_range(0, 3) == 0);
      cyc(we, re, a, d, s);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
